// File: rtl/ram_request_sequencer.sv
// Command FIFO plus issue sequencer in front of the RAM controller: one request per
// command, then wait for completion or timeout and report read data or an error.
module ram_request_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [23:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        ram_op,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        ram_req,
   input  logic        ram_done,
   input  logic [15:0] ram_rdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

   typedef struct packed {
      logic        write;
      logic [23:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   cmd_t          mem [FIFO_DEPTH];
   cmd_t          head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;
   state_t        state;
   state_t        state_next;
   logic          push;
   logic          pop;
   logic          done_hit;
   logic          timeout_hit;

   assign cmd_ready = (count != FULL_COUNT);
   assign busy      = (state != IDLE) || (count != '0);
   assign push      = cmd_valid && cmd_ready && !rst;
   assign head      = mem[rd_ptr];

   // ---------------- command FIFO ----------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
      state_next = state;
      unique case (state)
         IDLE:    if (pop) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT: begin
            if (done_hit)         state_next = IDLE;
            else if (timeout_hit) state_next = RECOVER;
         end
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: output decode ----------------
   // Done takes priority over the terminal count when both land in the same WAIT cycle.
   always_comb begin
      pop         = (state == IDLE) && (count != '0);
      done_hit    = (state == WAIT) && ram_done;
      timeout_hit = (state == WAIT) && !ram_done && (timer == TIMER_LAST);
   end

   // ---------------- registered outputs and timeout counter ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_op    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_req   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
         timer     <= '0;
      end else begin
         ram_req   <= pop;
         rsp_valid <= done_hit && !ram_op;
         rsp_error <= timeout_hit;
         // Holding registers change only on a pop, so they stay stable through WAIT.
         if (pop) begin
            ram_op    <= head.write;
            ram_addr  <= head.addr;
            ram_wdata <= head.wdata;
         end
         if (done_hit && !ram_op) rsp_rdata <= ram_rdata;
         if (state == ISSUE)     timer <= '0;
         else if (state == WAIT) timer <= timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_ram_request_sequencer.sv
// Self-checking bench for ram_request_sequencer: per-cycle vector table, directed
// corner sequences, then random traffic against a transaction-level model.
module tb_ram_request_sequencer;
   localparam int DEPTH = 4;
   localparam int TMO   = 15;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [23:0] cmd_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        ram_op;
   logic [23:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_req;
   logic        ram_done = 1'b0;
   logic [15:0] ram_rdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;

   always #5 clk = ~clk;

   ram_request_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .ram_op(ram_op), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_req(ram_req),
      .ram_done(ram_done), .ram_rdata(ram_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy)
   );

   int n_vec = 0;
   int n_bad = 0;
   int n_acc = 0;
   logic [23:0] issued[$];

   typedef struct {
      logic        valid;
      logic        write;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic        done;
      logic [15:0] rdata;
      logic        e_ready;
      logic        e_req;
      logic        e_op;
      logic [23:0] e_addr;
      logic [15:0] e_wdata;
      logic        e_rv;
      logic [15:0] e_rdata;
      logic        e_err;
      logic        e_busy;
   } vec_t;

   typedef struct packed {
      logic        write;
      logic [23:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      logic rdy;
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (cmd_valid && rdy && !rst) begin
         n_acc++;
         cmd_valid = 1'b0;
      end
      if (ram_req) issued.push_back(ram_addr);
   endtask

   task automatic drive_cmd(input logic w, input logic [23:0] a, input logic [15:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_ram_op"},    32'(ram_op),    32'h0);
      check({tag, "_ram_addr"},  32'(ram_addr),  32'h0);
      check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'h0);
      check({tag, "_ram_req"},   32'(ram_req),   32'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
      check({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
      check({tag, "_busy"},      32'(busy),      32'h0);
   endtask

   function automatic vec_t mk(
      input logic v, input logic w, input logic [23:0] a, input logic [15:0] d,
      input logic dn, input logic [15:0] rd,
      input logic er, input logic eq, input logic eo, input logic [23:0] ea,
      input logic [15:0] ew, input logic ev, input logic [15:0] erd,
      input logic ee, input logic eb);
      vec_t r;
      r.valid = v; r.write = w; r.addr = a; r.wdata = d; r.done = dn; r.rdata = rd;
      r.e_ready = er; r.e_req = eq; r.e_op = eo; r.e_addr = ea; r.e_wdata = ew;
      r.e_rv = ev; r.e_rdata = erd; r.e_err = ee; r.e_busy = eb;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[11];
      cmd_t q[$];
      cmd_t cur;
      cmd_t hold;
      cmd_t drv;
      bit   idle;
      bit   recover;
      bit   outstanding;
      bit   seen;
      int   since_req;
      int   plan_k;
      logic [15:0] exp_rdata;

      // ---- single write then single read, one row per clock ----
      //          in: valid write addr        wdata     done rdata      exp: ready req op addr        wdata     rv rdata     err busy
      tbl[0]  = mk(T, T, 24'h000010, 16'hBEEF, F, 16'h0000,  T, F, F, 24'h000000, 16'h0000, F, 16'h0000, F, T);
      tbl[1]  = mk(F, F, 24'h000000, 16'h0000, F, 16'h0000,  T, T, T, 24'h000010, 16'hBEEF, F, 16'h0000, F, T);
      tbl[2]  = mk(F, F, 24'h000000, 16'h0000, F, 16'h0000,  T, F, T, 24'h000010, 16'hBEEF, F, 16'h0000, F, T);
      tbl[3]  = mk(F, F, 24'h000000, 16'h0000, F, 16'h0000,  T, F, T, 24'h000010, 16'hBEEF, F, 16'h0000, F, T);
      tbl[4]  = mk(F, F, 24'h000000, 16'h0000, T, 16'h9999,  T, F, T, 24'h000010, 16'hBEEF, F, 16'h0000, F, F);
      tbl[5]  = mk(T, F, 24'h0000A5, 16'h5555, F, 16'h0000,  T, F, T, 24'h000010, 16'hBEEF, F, 16'h0000, F, T);
      tbl[6]  = mk(F, F, 24'h000000, 16'h0000, F, 16'h0000,  T, T, F, 24'h0000A5, 16'h5555, F, 16'h0000, F, T);
      tbl[7]  = mk(F, F, 24'h000000, 16'h0000, F, 16'h0000,  T, F, F, 24'h0000A5, 16'h5555, F, 16'h0000, F, T);
      tbl[8]  = mk(F, F, 24'h000000, 16'h0000, T, 16'h1234,  T, F, F, 24'h0000A5, 16'h5555, T, 16'h1234, F, F);
      tbl[9]  = mk(F, F, 24'h000000, 16'h0000, F, 16'hFFFF,  T, F, F, 24'h0000A5, 16'h5555, F, 16'h1234, F, F);
      tbl[10] = mk(F, F, 24'h000000, 16'h0000, T, 16'hAAAA,  T, F, F, 24'h0000A5, 16'h5555, F, 16'h1234, F, F);

      // ---- reset with cmd_valid high: nothing may be pushed ----
      rst = 1'b1;
      drive_cmd(1'b1, 24'h00ABCD, 16'h1111);
      step();
      cmd_valid = 1'b1;
      step();
      check_idle_zero("reset");
      rst = 1'b0;
      cmd_valid = 1'b0;
      step();
      check_idle_zero("after_reset");

      for (int i = 0; i < 11; i++) begin
         cmd_valid = tbl[i].valid;
         cmd_write = tbl[i].write;
         cmd_addr  = tbl[i].addr;
         cmd_wdata = tbl[i].wdata;
         ram_done  = tbl[i].done;
         ram_rdata = tbl[i].rdata;
         step();
         check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_ready));
         check($sformatf("vec%0d_ram_req", i),   32'(ram_req),   32'(tbl[i].e_req));
         check($sformatf("vec%0d_ram_op", i),    32'(ram_op),    32'(tbl[i].e_op));
         check($sformatf("vec%0d_ram_addr", i),  32'(ram_addr),  32'(tbl[i].e_addr));
         check($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].e_wdata));
         check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
         check($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rdata));
         check($sformatf("vec%0d_rsp_error", i), 32'(rsp_error), 32'(tbl[i].e_err));
         check($sformatf("vec%0d_busy", i),      32'(busy),      32'(tbl[i].e_busy));
      end
      cmd_valid = 1'b0;
      ram_done  = 1'b0;

      // ---- full FIFO: six writes with done held low ----
      issued.delete();
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         drive_cmd(1'b1, 24'(32'h100 + i), 16'(i));
         step();
      end
      check("fill_accepts", 32'(n_acc), 32'd5);
      check("fill_ready_low", 32'(cmd_ready), 32'h0);
      drive_cmd(1'b1, 24'h000105, 16'h0005);
      step();
      check("sixth_stalls", 32'(n_acc), 32'd5);
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < 40 && issued.size() <= i; b++) step();
         check($sformatf("fill_req%0d_seen", i), 32'(issued.size() > i), 32'h1);
         check($sformatf("fill_req%0d_addr", i), 32'(issued[i]), 32'(32'h100 + i));
         check($sformatf("fill_req%0d_no_err", i), 32'(rsp_error), 32'h0);
         ram_done = 1'b1;
         step();
         step();
         ram_done = 1'b0;
      end
      check("sixth_accepted", 32'(n_acc), 32'd6);
      check("fill_issue_count", 32'(issued.size()), 32'd6);
      step();
      check("fill_drained_busy", 32'(busy), 32'h0);

      // ---- timeout on a read, then done/terminal-count tie on the next read ----
      issued.delete();
      drive_cmd(1'b0, 24'h000200, 16'h0000);
      step();
      drive_cmd(1'b0, 24'h000201, 16'h0000);
      step();
      check("tmo_req_seen", 32'(issued.size()), 32'd1);
      check("tmo_req_addr", 32'(ram_addr), 32'h200);
      step();
      seen = 1'b0;
      for (int k = 1; k < TMO; k++) begin
         step();
         seen = seen | rsp_error | rsp_valid;
      end
      check("tmo_no_early_rsp", 32'(seen), 32'h0);
      step();
      check("tmo_error_pulse", 32'(rsp_error), 32'h1);
      check("tmo_no_valid", 32'(rsp_valid), 32'h0);
      step();
      check("recover_error_low", 32'(rsp_error), 32'h0);
      check("recover_no_req", 32'(ram_req), 32'h0);
      check("recover_busy", 32'(busy), 32'h1);
      step();
      check("after_recover_req", 32'(ram_req), 32'h1);
      check("after_recover_addr", 32'(ram_addr), 32'h201);
      step();
      for (int k = 1; k < TMO; k++) step();
      ram_done  = 1'b1;
      ram_rdata = 16'h7777;
      step();
      ram_done  = 1'b0;
      check("tie_valid", 32'(rsp_valid), 32'h1);
      check("tie_no_error", 32'(rsp_error), 32'h0);
      check("tie_rdata", 32'(rsp_rdata), 32'h7777);
      step();
      check("tie_no_late_error", 32'(rsp_error), 32'h0);
      check("tie_idle", 32'(busy), 32'h0);

      // ---- reset in WAIT with two commands queued ----
      for (int i = 0; i < 3; i++) begin
         drive_cmd(1'b1, 24'(32'h300 + i), 16'h0ABC);
         step();
      end
      step();
      check("midwait_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle_zero("midwait_reset");
      ram_done  = 1'b1;
      ram_rdata = 16'h4321;
      step();
      ram_done = 1'b0;
      check("late_done_no_valid", 32'(rsp_valid), 32'h0);
      check("late_done_no_error", 32'(rsp_error), 32'h0);
      check("late_done_no_req", 32'(ram_req), 32'h0);
      step();
      check("flushed_no_req", 32'(ram_req), 32'h0);
      check("flushed_busy", 32'(busy), 32'h0);

      // ---- random traffic against a transaction-level model ----
      idle = 1'b1;
      recover = 1'b0;
      outstanding = 1'b0;
      since_req = 0;
      plan_k = 0;
      hold = '0;
      cur = '0;
      exp_rdata = 16'h0000;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic rdy_before;
         logic done_drv;
         logic [15:0] rd_now;
         int   pre_q;
         bit   pre_idle;
         bit   exp_req;
         bit   exp_rv;
         bit   exp_err;

         drv.write = 1'($urandom_range(0, 1));
         drv.addr  = 24'($urandom);
         drv.wdata = 16'($urandom);
         cmd_valid = ($urandom_range(0, 2) == 0);
         cmd_write = drv.write;
         cmd_addr  = drv.addr;
         cmd_wdata = drv.wdata;
         // Upcoming edge is WAIT sample number since_req when since_req >= 1.
         if (outstanding && since_req >= 1) done_drv = (since_req == plan_k);
         else                               done_drv = ($urandom_range(0, 3) == 0);
         ram_done  = done_drv;
         ram_rdata = 16'($urandom);
         rd_now    = ram_rdata;
         rdy_before = cmd_ready;
         pre_q      = q.size();
         pre_idle   = idle;

         @(posedge clk);
         #1;

         exp_req = pre_idle && (pre_q > 0);
         if (cmd_valid && rdy_before) q.push_back(drv);
         exp_rv  = 1'b0;
         exp_err = 1'b0;
         if (recover) begin
            recover = 1'b0;
            idle    = 1'b1;
         end
         if (outstanding) begin
            since_req++;
            if (since_req >= 2) begin
               if (done_drv) begin
                  outstanding = 1'b0;
                  idle = 1'b1;
                  if (!cur.write) begin
                     exp_rv    = 1'b1;
                     exp_rdata = rd_now;
                  end
               end else if (since_req - 1 == TMO) begin
                  outstanding = 1'b0;
                  recover = 1'b1;
                  exp_err = 1'b1;
               end
            end
         end
         check("rnd_ram_req", 32'(ram_req), 32'(exp_req));
         if (exp_req) begin
            cur = q.pop_front();
            hold = cur;
            outstanding = 1'b1;
            since_req = 0;
            plan_k = $urandom_range(1, TMO + 3);
            idle = 1'b0;
         end
         check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         check("rnd_rsp_error", 32'(rsp_error), 32'(exp_err));
         check("rnd_rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
         check("rnd_ram_op",    32'(ram_op),    32'(hold.write));
         check("rnd_ram_addr",  32'(ram_addr),  32'(hold.addr));
         check("rnd_ram_wdata", 32'(ram_wdata), 32'(hold.wdata));
         check("rnd_cmd_ready", 32'(cmd_ready), 32'(q.size() != DEPTH));
         check("rnd_busy",      32'(busy),      32'(!idle || q.size() != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
